// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute/write-back stage and the fetch/decode stage:
// opcode constants, execute FSM state encoding and pc width derivation.
package exec_unit_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_SHR  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MEM,
    S_EXEC,
    S_COMMIT,
    S_HALTED
  } state_e;

  // One extra bit so that out-of-range jump targets are representable and detectable.
  function automatic int pc_width(input int cap);
    return $clog2(cap) + 1;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Instruction handshake between fetch/decode (master) and execute (slave).
interface exec_unit_if
  import exec_unit_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int PC_W     = pc_width(20)
);
  logic                instr_valid;
  logic [3:0]          control_bus;
  logic [DATA_LEN-1:0] data;
  logic [PC_W-1:0]     pc;
  logic                fetch_req;

  modport master (output instr_valid, control_bus, data, input pc, fetch_req);
  modport slave  (input instr_valid, control_bus, data, output pc, fetch_req);
endinterface

// File: rtl/exec_alu.sv
// Combinational accumulator ALU; carry is passed through for ops that do not define it.
module exec_alu
  import exec_unit_pkg::*;
#(
  parameter int DATA_LEN = 8
) (
  input  logic [3:0]          op,
  input  logic [DATA_LEN-1:0] acc,
  input  logic [DATA_LEN-1:0] operand,
  input  logic                carry_in,
  output logic [DATA_LEN-1:0] result,
  output logic                carry_out,
  output logic                zero,
  output logic                acc_we
);
  logic [DATA_LEN:0] sum;
  logic [DATA_LEN:0] diff;

  // Bit DATA_LEN of the difference is the borrow (acc < operand).
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result    = acc;
    carry_out = carry_in;
    acc_we    = 1'b1;
    case (op)
      OP_LDI, OP_LDA:  result = operand;
      OP_ADD, OP_ADDI: {carry_out, result} = sum;
      OP_SUB:          {carry_out, result} = diff;
      OP_AND:          result = acc & operand;
      OP_OR:           result = acc | operand;
      OP_NOT:          result = ~acc;
      OP_SHL: begin
        carry_out = acc[DATA_LEN-1];
        result    = {acc[DATA_LEN-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_out = acc[0];
        result    = {1'b0, acc[DATA_LEN-1:1]};
      end
      OP_NOP, OP_STA, OP_HALT, OP_JMP, OP_JZ, OP_JC: acc_we = 1'b0;
      default: acc_we = 1'b0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute/write-back stage: runs one decoded instruction per fetch request against
// the accumulator and local data memory, then hands the next pc back to fetch/decode.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int INST_CAP   = 20,
  parameter int DATA_LEN   = 8,
  parameter int DMEM_DEPTH = 256,
  parameter int PC_W       = pc_width(INST_CAP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  exec_unit_if.slave          bus,
  output logic [DATA_LEN-1:0] acc,
  output logic                zero,
  output logic                carry,
  output logic                busy,
  output logic                halted,
  output logic                err
);
  localparam int AW = $clog2(DMEM_DEPTH);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_seq, target;
  logic [DATA_LEN-1:0] acc_q, acc_d;
  logic                zero_q, zero_d, carry_q, carry_d;
  logic                halted_q, halted_d, err_q, err_d;
  logic [3:0]          op_q;
  logic [DATA_LEN-1:0] opnd_q, mem_rd_q, alu_b, alu_result;
  logic                alu_carry, alu_zero, alu_we, mem_we, jump_taken;
  logic [DATA_LEN-1:0] mem_q [DMEM_DEPTH];

  assign alu_b      = is_mem_op(op_q) ? mem_rd_q : opnd_q;
  assign pc_seq     = (pc_q == PC_W'(INST_CAP - 1)) ? '0 : pc_q + 1'b1;
  assign target     = opnd_q[PC_W-1:0];
  assign jump_taken = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_q) ||
                      ((op_q == OP_JC) && carry_q);

  exec_alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .op        (op_q),
    .acc       (acc_q),
    .operand   (alu_b),
    .carry_in  (carry_q),
    .result    (alu_result),
    .carry_out (alu_carry),
    .zero      (alu_zero),
    .acc_we    (alu_we)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE:   if (en && !halted_q) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   if (bus.instr_valid) state_d = is_mem_op(bus.control_bus) ? S_MEM : S_EXEC;
      S_MEM:    state_d = S_EXEC;
      S_EXEC: begin
        if (alu_we) begin
          acc_d  = alu_result;
          zero_d = alu_zero;
        end
        carry_d = alu_carry;
        mem_we  = (op_q == OP_STA);
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        // A bad jump target leaves pc pointing at the offending jump.
        if (op_q == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else if (jump_taken && (target >= PC_W'(INST_CAP))) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          pc_d    = jump_taken ? target : pc_seq;
          state_d = en ? S_REQ : S_IDLE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Instruction latch and data memory hold contents across reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_WAIT) && bus.instr_valid) begin
      op_q   <= bus.control_bus;
      opnd_q <= bus.data;
    end
    if (mem_we) mem_q[opnd_q[AW-1:0]] <= acc_q;
    if (state_q == S_MEM) mem_rd_q <= mem_q[opnd_q[AW-1:0]];
  end

  assign bus.pc        = pc_q;
  assign bus.fetch_req = (state_q == S_REQ);
  assign acc           = acc_q;
  assign zero          = zero_q;
  assign carry         = carry_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted        = halted_q;
  assign err           = err_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: a reference model predicts the architectural state
// seen at each following fetch_req; a negedge monitor pops and compares it.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int PC_W = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] acc;
  logic       zero, carry, busy, halted, err;

  exec_unit_if #(.DATA_LEN(8), .PC_W(PC_W)) bus ();

  exec_unit #(.INST_CAP(20), .DATA_LEN(8), .DMEM_DEPTH(256), .PC_W(PC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .bus    (bus),
    .acc    (acc),
    .zero   (zero),
    .carry  (carry),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [7:0]      acc;
    logic            zero;
    logic            carry;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [PC_W-1:0] m_pc;
  logic [7:0]      m_acc;
  logic            m_zero, m_carry, m_halt, m_err;
  logic [7:0]      m_mem [256];

  // Scoreboard monitor: every fetch_req must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && bus.fetch_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch: fetch_req at pc=%0d, required none", bus.pc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pc !== e.pc) begin errors++; $display("FAIL sb_pc: got %0d, expected %0d", bus.pc, e.pc); end
        checks++;
        if (acc !== e.acc) begin errors++; $display("FAIL sb_acc: got %02h, expected %02h", acc, e.acc); end
        checks++;
        if (zero !== e.zero) begin errors++; $display("FAIL sb_zero: got %0b, expected %0b", zero, e.zero); end
        checks++;
        if (carry !== e.carry) begin errors++; $display("FAIL sb_carry: got %0b, expected %0b", carry, e.carry); end
      end
    end
  end

  task automatic model_reset();
    m_pc = '0; m_acc = 8'h00; m_zero = 1'b1; m_carry = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [7:0] d);
    logic [8:0]      t;
    logic [7:0]      m;
    logic [PC_W-1:0] tgt;
    logic            jmp, wr;
    m = m_mem[d]; jmp = 1'b0; wr = 1'b1;
    case (op)
      4'h1: m_acc = d;
      4'h2: m_acc = m;
      4'h4: begin t = {1'b0, m_acc} + {1'b0, m}; m_carry = t[8]; m_acc = t[7:0]; end
      4'h5: begin m_carry = (m_acc < m); m_acc = m_acc - m; end
      4'h6: m_acc = m_acc & m;
      4'h7: m_acc = m_acc | m;
      4'h9: begin t = {1'b0, m_acc} + {1'b0, d}; m_carry = t[8]; m_acc = t[7:0]; end
      4'hD: m_acc = ~m_acc;
      4'hE: begin m_carry = m_acc[7]; m_acc = {m_acc[6:0], 1'b0}; end
      4'hF: begin m_carry = m_acc[0]; m_acc = {1'b0, m_acc[7:1]}; end
      default: begin
        wr = 1'b0;
        if (op == 4'h3) m_mem[d] = m_acc;
        if (op == 4'hA) jmp = 1'b1;
        if (op == 4'hB) jmp = m_zero;
        if (op == 4'hC) jmp = m_carry;
      end
    endcase
    if (wr) m_zero = (m_acc == 8'h00);
    if (op == 4'h8) m_halt = 1'b1;
    else if (jmp) begin
      tgt = d[PC_W-1:0];
      if (tgt >= 20) begin m_err = 1'b1; m_halt = 1'b1; end
      else m_pc = tgt;
    end else m_pc = (m_pc == 19) ? '0 : m_pc + 1'b1;
  endtask

  // Entered at the negedge of a fetch_req cycle; returns at the next fetch_req or after 12 cycles.
  task automatic issue(input logic [3:0] op, input logic [7:0] d, output int lat, output logic fetched);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.control_bus = op; bus.data = d;
    model_exec(op, d);
    if (!m_halt) exp_q.push_back('{pc: m_pc, acc: m_acc, zero: m_zero, carry: m_carry});
    lat = 0; fetched = 1'b0;
    for (int i = 0; i < 12 && !fetched; i++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      lat++;
      if (bus.fetch_req) fetched = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_run();
    logic seen;
    seen = 1'b0;
    exp_q.push_back('{pc: m_pc, acc: m_acc, zero: m_zero, carry: m_carry});
    en = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.fetch_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL start_fetch: got no fetch_req, expected one within 10 cycles"); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 6'd0) begin errors++; $display("FAIL rst_pc: got %0d, expected 0", bus.pc); end
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL rst_acc: got %02h, expected 00", acc); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %0b, expected 1", zero); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL rst_carry: got %0b, expected 0", carry); end
    checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rst_fetch: got %0b, expected 0", bus.fetch_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, expected 0", busy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b, expected 0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b, expected 0", err); end
    do_reset();
    start_run();
  endtask

  task automatic test_alu_basic();
    int lat; logic f;
    issue(OP_LDI, 8'h05, lat, f);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lat_ldi: got %0d, expected 3", lat); end
    issue(OP_ADDI, 8'hFE, lat, f);
    checks++; if (acc !== 8'h03 || carry !== 1'b1 || zero !== 1'b0 || bus.pc !== 6'd2) begin
      errors++; $display("FAIL addi_state: got acc=%02h c=%0b z=%0b pc=%0d, expected acc=03 c=1 z=0 pc=2", acc, carry, zero, bus.pc);
    end
  endtask

  task automatic test_memory();
    int lat; logic f;
    issue(OP_STA, 8'h10, lat, f);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lat_sta: got %0d, expected 3", lat); end
    issue(OP_LDI, 8'h00, lat, f);
    issue(OP_LDA, 8'h10, lat, f);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lat_lda: got %0d, expected 4", lat); end
    checks++; if (acc !== 8'h03) begin errors++; $display("FAIL lda_acc: got %02h, expected 03", acc); end
  endtask

  task automatic test_branch();
    int lat; logic f;
    issue(OP_LDI, 8'h00, lat, f);
    issue(OP_JZ, 8'h07, lat, f);
    checks++; if (bus.pc !== 6'd7) begin errors++; $display("FAIL jz_taken: got pc=%0d, expected 7", bus.pc); end
    issue(OP_LDI, 8'h01, lat, f);
    issue(OP_NOP, 8'h00, lat, f);
    issue(OP_JZ, 8'h07, lat, f);
    checks++; if (bus.pc !== 6'd10) begin errors++; $display("FAIL jz_not_taken: got pc=%0d, expected 10", bus.pc); end
    issue(OP_LDI, 8'h80, lat, f);
    issue(OP_SHL, 8'h00, lat, f);
    issue(OP_JC, 8'h0E, lat, f);
    checks++; if (bus.pc !== 6'd14) begin errors++; $display("FAIL jc_taken: got pc=%0d, expected 14", bus.pc); end
  endtask

  task automatic test_alu_ops();
    int lat; logic f;
    issue(OP_LDI, 8'h01, lat, f);
    issue(OP_SUB, 8'h10, lat, f);
    checks++; if (acc !== 8'hFE || carry !== 1'b1) begin errors++; $display("FAIL sub_borrow: got acc=%02h c=%0b, expected acc=FE c=1", acc, carry); end
    issue(OP_AND, 8'h10, lat, f);
    issue(OP_OR, 8'h10, lat, f);
    issue(OP_NOT, 8'h00, lat, f);
    issue(OP_SHL, 8'h00, lat, f);
    issue(OP_SHR, 8'h00, lat, f);
    issue(OP_ADD, 8'h10, lat, f);
    issue(OP_ADDI, 8'h81, lat, f);
    checks++; if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin errors++; $display("FAIL addi_wrap: got acc=%02h z=%0b c=%0b, expected acc=00 z=1 c=1", acc, zero, carry); end
    issue(OP_SUB, 8'h10, lat, f);
    checks++; if (acc !== 8'hFD) begin errors++; $display("FAIL sub_wrap: got %02h, expected FD", acc); end
  endtask

  task automatic test_wrap_and_err();
    int lat; logic f; int nf;
    for (int i = 0; i < 25 && m_pc != 19; i++) issue(OP_NOP, 8'h00, lat, f);
    issue(OP_NOP, 8'h00, lat, f);
    checks++; if (bus.pc !== 6'd0) begin errors++; $display("FAIL pc_wrap: got %0d, expected 0", bus.pc); end
    issue(OP_JMP, 8'h1F, lat, f);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL err_fetch: got fetch_req after bad jump, expected none"); end
    checks++; if (err !== 1'b1 || halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_flags: got err=%0b halted=%0b busy=%0b, expected 1 1 0", err, halted, busy); end
    checks++; if (bus.pc !== 6'd0) begin errors++; $display("FAIL err_pc: got %0d, expected 0", bus.pc); end
    nf = 0;
    repeat (10) begin @(negedge clk); if (bus.fetch_req) nf++; end
    checks++; if (nf !== 0) begin errors++; $display("FAIL err_absorb: got %0d fetches, expected 0", nf); end
  endtask

  task automatic test_halt();
    int lat; logic f; int nf;
    do_reset();
    start_run();
    issue(OP_LDI, 8'h2A, lat, f);
    issue(OP_HALT, 8'h00, lat, f);
    checks++; if (f !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL halt_state: got fetch=%0b halted=%0b busy=%0b err=%0b, expected 0 1 0 0", f, halted, busy, err);
    end
    nf = 0;
    repeat (3) begin
      @(negedge clk); bus.instr_valid = 1'b1; bus.control_bus = OP_LDI; bus.data = 8'h55;
      @(negedge clk); bus.instr_valid = 1'b0;
      if (bus.fetch_req) nf++;
    end
    checks++; if (acc !== 8'h2A || nf !== 0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_ignore: got acc=%02h fetches=%0d halted=%0b, expected acc=2A 0 1", acc, nf, halted);
    end
    rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || acc !== 8'h00 || bus.pc !== 6'd0 || zero !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_rst: got halted=%0b acc=%02h pc=%0d z=%0b busy=%0b, expected 0 00 0 1 0", halted, acc, bus.pc, zero, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_en_drop_and_rst();
    int lat; logic f; int nf; logic seen;
    start_run();
    issue(OP_LDI, 8'h10, lat, f);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.control_bus = OP_ADD; bus.data = 8'h10;
    model_exec(OP_ADD, 8'h10);
    exp_q.push_back('{pc: m_pc, acc: m_acc, zero: m_zero, carry: m_carry});
    @(negedge clk);
    bus.instr_valid = 1'b0; en = 1'b0;
    nf = 0;
    repeat (10) begin @(negedge clk); if (bus.fetch_req) nf++; end
    checks++; if (nf !== 0 || acc !== 8'h13 || busy !== 1'b0 || bus.pc !== 6'd2) begin
      errors++; $display("FAIL en_drop: got fetches=%0d acc=%02h busy=%0b pc=%0d, expected 0 13 0 2", nf, acc, busy, bus.pc);
    end
    en = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bus.fetch_req) seen = 1'b1; end
    checks++; if (!seen) begin errors++; $display("FAIL en_resume: got no fetch_req, expected one"); end
    issue(OP_STA, 8'h30, lat, f);
    issue(OP_LDI, 8'h44, lat, f);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.control_bus = OP_STA; bus.data = 8'h30;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (acc !== 8'h00 || bus.pc !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_exec: got acc=%02h pc=%0d busy=%0b, expected 00 0 0", acc, bus.pc, busy);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    model_reset();
    start_run();
    issue(OP_LDA, 8'h30, lat, f);
    checks++; if (acc !== 8'h13) begin errors++; $display("FAIL sta_aborted: got %02h, expected 13", acc); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.control_bus = 4'h8;
    bus.data        = 8'h00;
    test_reset();
    test_alu_basic();
    test_memory();
    test_branch();
    test_alu_ops();
    test_wrap_and_err();
    test_halt();
    test_en_drop_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
